// File: rtl/if_id_fetch_buffer.sv
// Fetch-to-decode FIFO: buffers {PC, instruction} pairs, tags fetch address errors
// and branch-delay-slot membership, and stalls the PC register when full.
module if_id_fetch_buffer #(
    parameter int unsigned DEPTH   = 2,
    parameter logic [31:0] IM_BASE = 32'h0000_3000,
    parameter logic [31:0] IM_SIZE = 32'h0000_1000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    input  logic [31:0]              in_pc_i,
    input  logic [31:0]              in_instr_i,
    output logic                     in_ready_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [31:0]              out_pc_o,
    output logic [31:0]              out_pc_plus_8_o,
    output logic [31:0]              out_instr_o,
    output logic [4:0]               out_exc_code_o,
    output logic                     out_bd_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
    localparam logic [4:0] ExcAdEL = 5'd4;

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            last_br_q, last_br_d;

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];
    logic [4:0]  exc_mem   [DEPTH];
    logic        bd_mem    [DEPTH];

    logic        push, pop;
    logic        fetch_exc, st_is_br;
    logic [31:0] st_instr;
    logic [4:0]  st_exc;
    logic [32:0] pc_ext, im_lo, im_hi;

    assign in_ready_o  = (count_q < DepthCnt);
    assign out_valid_o = (count_q != '0);
    assign push = in_valid_i && in_ready_o && !flush_i;
    assign pop  = out_valid_o && out_ready_i && !flush_i;

    // 33-bit compare so IM_BASE + IM_SIZE cannot wrap.
    assign pc_ext    = {1'b0, in_pc_i};
    assign im_lo     = {1'b0, IM_BASE};
    assign im_hi     = {1'b0, IM_BASE} + {1'b0, IM_SIZE};
    assign fetch_exc = (in_pc_i[1:0] != 2'b00) || (pc_ext < im_lo) || (pc_ext >= im_hi);
    assign st_instr  = fetch_exc ? 32'h0 : in_instr_i;
    assign st_exc    = fetch_exc ? ExcAdEL : 5'd0;

    always_comb begin
        st_is_br = 1'b0;
        if (st_instr[31:26] inside {6'b000001, 6'b000010, 6'b000011, 6'b000100,
                                    6'b000101, 6'b000110, 6'b000111}) begin
            st_is_br = 1'b1;
        end else if (st_instr[31:26] == 6'b000000 &&
                     st_instr[5:0] inside {6'b001000, 6'b001001}) begin
            st_is_br = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        last_br_d = last_br_q;
        if (flush_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            last_br_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d  = wr_ptr_q + PtrW'(1);
                last_br_d = st_is_br;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            last_br_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            last_br_q <= last_br_d;
        end
    end

    // Storage needs no reset: the head outputs are gated by occupancy.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= in_pc_i;
            instr_mem[wr_ptr_q] <= st_instr;
            exc_mem[wr_ptr_q]   <= st_exc;
            bd_mem[wr_ptr_q]    <= last_br_q;
        end
    end

    always_comb begin
        out_pc_o       = 32'h0;
        out_instr_o    = 32'h0;
        out_exc_code_o = 5'd0;
        out_bd_o       = 1'b0;
        if (out_valid_o) begin
            out_pc_o       = pc_mem[rd_ptr_q];
            out_instr_o    = instr_mem[rd_ptr_q];
            out_exc_code_o = exc_mem[rd_ptr_q];
            out_bd_o       = bd_mem[rd_ptr_q];
        end
    end

    assign out_pc_plus_8_o = out_pc_o + 32'd8;
    assign count_o         = count_q;

endmodule

// File: doc/if_id_fetch_buffer.md
Name: if_id_fetch_buffer

Overview:
Fetch-to-decode buffer directly downstream of the PC register and instruction memory. It captures each fetched {PC, instruction} pair into a small FIFO and presents it to the decode stage with a valid/ready handshake. Its in_ready output drives the PC register's enable, so a full buffer stalls fetch. Per entry, it also tags the fetch-stage address-error exception and the branch-delay-slot flag consumed by CP0.

Parameters:
DEPTH, 2, FIFO entries; power of two, at least 2
IM_BASE, 32'h00003000, lowest legal fetch address
IM_SIZE, 32'h00001000, instruction memory size in bytes; legal range is [IM_BASE, IM_BASE+IM_SIZE)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous clear: exception or eret redirect
in_valid  input  1  fetch pair valid this cycle
in_pc  input  32  fetch address
in_instr  input  32  instruction word read at in_pc
in_ready  output  1  buffer can accept; drives the PC register enable
out_valid  output  1  head entry valid
out_ready  input  1  decode stage accepts the head entry (not stalled)
out_pc  output  32  head entry PC
out_pc_plus_8  output  32  out_pc + 8 (link address)
out_instr  output  32  head entry instruction (NOP on exception)
out_exc_code  output  5  0 = none; 4 = AdEL on fetch
out_bd  output  1  head entry is in a branch delay slot
count  output  log2(DEPTH)+1  current occupancy

Behaviour:
- Reset is asynchronous and forces, without waiting for a clock edge:
  - count = 0, read and write pointers = 0, last_was_branch = 0.
  - Outputs: out_valid = 0, in_ready = 1, out_pc = 0, out_instr = 0, out_exc_code = 0, out_bd = 0. out_pc_plus_8 = 8 (it is always out_pc + 8).
- in_ready = (count < DEPTH). It depends on count only, never on out_ready. A full buffer refuses a push even in a cycle where it pops.
- out_valid = (count != 0). There is no bypass: an entry pushed at edge N is visible on the outputs after edge N.
- When empty, the head outputs are driven to 0 (out_pc_plus_8 = 8).
- Push occurs when in_valid && in_ready && !flush. Pop occurs when out_valid && out_ready && !flush.
- Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- Exception tagging at push:
  - Condition: in_pc[1:0] != 0, or in_pc < IM_BASE, or in_pc >= IM_BASE + IM_SIZE.
  - On the condition: store instr = 32'h0, exc_code = 5'd4.
  - Otherwise: store in_instr, exc_code = 0.
  - Compare with 33-bit unsigned arithmetic so IM_BASE + IM_SIZE cannot overflow.
- Delay-slot tagging at push:
  - The stored bd = last_was_branch. On every push, last_was_branch then updates to is_branch(stored instr).
  - is_branch is true for opcode[31:26] in {000001, 000010, 000011, 000100, 000101, 000110, 000111}.
  - It is also true for opcode 000000 with funct[5:0] in {001000, 001001} (jr, jalr).
  - A NOP from an exception is not a branch.
- flush (priority over push and pop):
  - At the edge it sets count = 0, both pointers = 0, last_was_branch = 0.
  - Any push or pop in that cycle is discarded. in_ready that cycle still follows count.
- out_pc_plus_8 is combinational from the head entry, with a 32-bit wrapping add.
- Reset asserted mid-operation discards all entries immediately. The first push after reset deassertion has bd = 0.

Test Plan:
- Reset, then push pc=3000 instr=24010005 with out_ready=0 -> next cycle out_valid=1, out_pc=3000, out_pc_plus_8=3008, exc=0, bd=0, count=1.
- Hold out_ready=0 and push 3004, then attempt 3008 -> count=2, in_ready=0, 3008 not stored. Raise out_ready -> pops in order 3000, 3004.
- Push beq (10220003) at 3000, then 3004 -> 3000 has bd=0, 3004 has bd=1. Push jr (03e00008) at 3008, then 300c -> 300c has bd=1.
- Push pc=3002, then pc=4000 -> both give out_instr=0 and exc=4. Push pc=2ffc -> exc=4. Push pc=3ffc -> exc=0.
- With count=2, assert flush together with in_valid and out_ready -> next cycle count=0, out_valid=0, in_ready=1. The next push has bd=0.
- With count=1, assert reset asynchronously between clock edges -> out_valid=0 and count=0 before the next rising edge.
